// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one RAM between instruction fetch and data access.
// The data port has priority, except that a port is skipped in its own ready cycle so the other port can win.
module mem_arbiter #(
  parameter int RAM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_sel,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_sel,
  input  logic [31:0] ram_rdata
);

  // Latencies outside the supported range fall back to single-cycle RAM.
  localparam int         LAT  = (RAM_LATENCY >= 1 && RAM_LATENCY <= 4) ? RAM_LATENCY : 1;
  localparam logic [1:0] LAST = 2'(LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  state_t     state, state_next;
  logic [1:0] cnt, cnt_next;
  logic       txn_we;
  logic       grant_mem, grant_if, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Registered ready outputs double as "just completed" flags.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    grant_mem  = 1'b0;
    grant_if   = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req && !mem_ready) begin
          grant_mem  = 1'b1;
          state_next = BUSY_MEM;
          cnt_next   = 2'd0;
        end else if (if_req && !if_ready) begin
          grant_if   = 1'b1;
          state_next = BUSY_IF;
          cnt_next   = 2'd0;
        end
      end
      BUSY_IF, BUSY_MEM: begin
        if (cnt == LAST) begin
          done       = 1'b1;
          state_next = IDLE;
          cnt_next   = 2'd0;
        end else begin
          cnt_next = cnt + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM strobes exist only for the single cycle after a grant; read data is captured on the last busy edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_ce    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= 32'd0;
      ram_wdata <= 32'd0;
      ram_sel   <= 4'd0;
      txn_we    <= 1'b0;
      if_ready  <= 1'b0;
      if_rdata  <= 32'd0;
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      ram_ce    <= grant_mem | grant_if;
      ram_we    <= grant_mem & mem_we;
      ram_addr  <= grant_mem ? mem_addr : (grant_if ? if_addr : 32'd0);
      ram_wdata <= grant_mem ? mem_wdata : 32'd0;
      ram_sel   <= grant_mem ? mem_sel : (grant_if ? 4'hF : 4'd0);
      if (grant_mem) begin
        txn_we <= mem_we;
      end
      if_ready  <= done && (state == BUSY_IF);
      mem_ready <= done && (state == BUSY_MEM);
      if_rdata  <= (done && (state == BUSY_IF)) ? ram_rdata : 32'd0;
      mem_rdata <= (done && (state == BUSY_MEM) && !txn_we) ? ram_rdata : 32'd0;
    end
  end

endmodule
